game_status: RTL and testbench

// Game-state keeper upstream of the win/loss message overlay. It counts down the play timer
// and decrements the remaining-coin count on collision events. It drives coins_left and

---
 rtl/game_status_pkg.sv | 18 +
 rtl/game_status_tick_gen.sv | 42 ++++
 rtl/game_status.sv | 116 +++++++++++
 tb/tb_game_status.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_status_pkg.sv
// Shared definitions for the game-state keeper, the message overlay and the HUD.
package game_status_pkg;

    // FSM encodings are fixed because the overlay and HUD decode them too.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_WIN  = 2'd2,
        S_LOSS = 2'd3
    } state_e;

    localparam int DEF_TICK_DIV    = 25_000_000;
    localparam int DEF_START_COINS = 10;
    localparam int DEF_START_TIME  = 60;
    localparam int DEF_TIMER_W     = 7;
    localparam int COIN_W          = 4;

endpackage

// File: rtl/game_status_tick_gen.sv
// Seconds prescaler: counts 0..DIV-1 while enabled and flags the wrap cycle.
module tick_gen #(
    parameter int DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over counting; hold when disabled.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The wrap cycle is the second tick; a clear in the same cycle restarts the second instead.
    assign tick = en & ~clr & (cnt_q == LAST);

endmodule

// File: rtl/game_status.sv
// Game-state keeper: play timer, coin counter and IDLE/PLAY/WIN/LOSS FSM feeding the overlay.
module game_status
    import game_status_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int START_COINS = DEF_START_COINS,
    parameter int START_TIME  = DEF_START_TIME,
    parameter int TIMER_W     = DEF_TIMER_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               coin_hit,
    output logic [COIN_W-1:0]  coins_left,
    output logic [TIMER_W-1:0] timer,
    output logic               sec_pulse,
    output logic               game_over,
    output logic               win
);

    localparam logic [COIN_W-1:0]  COINS_RELOAD = COIN_W'(START_COINS);
    localparam logic [TIMER_W-1:0] TIME_RELOAD  = TIMER_W'(START_TIME);

    state_e             state_q, state_d;
    logic               start_q, coin_q;
    logic [COIN_W-1:0]  coins_q, coins_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               sec_q, sec_d;
    logic               over_q, over_d;
    logic               win_q, win_d;

    logic start_ev, coin_ev, reload, sec_tick;

    // Rising-edge events: current input against its registered copy.
    assign start_ev = start & ~start_q;
    assign coin_ev  = coin_hit & ~coin_q;
    // A start event restarts the game from any state except PLAY.
    assign reload   = start_ev & (state_q != S_PLAY);

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == S_PLAY),
        .clr  (reload),
        .tick (sec_tick)
    );

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d = state_q;
        coins_d = coins_q;
        timer_d = timer_q;
        sec_d   = 1'b0;
        case (state_q)
            S_PLAY: begin
                if (coin_ev && coins_q != '0) begin
                    coins_d = coins_q - COIN_W'(1);
                end
                if (coin_ev && coins_q == COIN_W'(1)) begin
                    // Collecting the last coin wins outright; a coincident tick is dropped
                    // so the timer stays non-zero and the overlay shows the win message.
                    state_d = S_WIN;
                end else if (sec_tick && timer_q != '0) begin
                    timer_d = timer_q - TIMER_W'(1);
                    sec_d   = 1'b1;
                    if (timer_q == TIMER_W'(1)) begin
                        // Out of time with coins remaining: zero coins so the overlay draws.
                        state_d = S_LOSS;
                        coins_d = '0;
                    end
                end
            end
            default: begin
                if (reload) begin
                    state_d = S_PLAY;
                    coins_d = COINS_RELOAD;
                    timer_d = TIME_RELOAD;
                end
            end
        endcase
        over_d = (state_d == S_WIN) || (state_d == S_LOSS);
        win_d  = (state_d == S_WIN);
    end

    // State, counters, edge-detect flops and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            coin_q  <= 1'b0;
            coins_q <= COINS_RELOAD;
            timer_q <= TIME_RELOAD;
            sec_q   <= 1'b0;
            over_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            coin_q  <= coin_hit;
            coins_q <= coins_d;
            timer_q <= timer_d;
            sec_q   <= sec_d;
            over_q  <= over_d;
            win_q   <= win_d;
        end
    end

    assign coins_left = coins_q;
    assign timer      = timer_q;
    assign sec_pulse  = sec_q;
    assign game_over  = over_q;
    assign win        = win_q;

endmodule

// File: tb/tb_game_status.sv
// Directed bench for game_status with TICK_DIV=4, START_COINS=3, START_TIME=5.
module tb_game_status;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       coin_hit;
    logic [3:0] coins_left;
    logic [6:0] timer;
    logic       sec_pulse;
    logic       game_over;
    logic       win;

    int checks = 0;
    int errors = 0;

    game_status #(
        .TICK_DIV    (4),
        .START_COINS (3),
        .START_TIME  (5),
        .TIMER_W     (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .coin_hit   (coin_hit),
        .coins_left (coins_left),
        .timer      (timer),
        .sec_pulse  (sec_pulse),
        .game_over  (game_over),
        .win        (win)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        coin_hit = 1'b0;
        #2 rst   = 1'b0;

        // 1. reset and idle
        cyc(2);
        chk("rst_coins", coins_left, 3);
        chk("rst_timer", timer, 5);
        chk("rst_over", game_over, 0);
        chk("rst_win", win, 0);
        chk("rst_sec", sec_pulse, 0);
        rst = 1'b1;
        cyc(20);
        chk("idle_coins", coins_left, 3);
        chk("idle_timer", timer, 5);
        chk("idle_over", game_over, 0);

        // 2. collect three coins -> WIN
        start = 1'b1;
        cyc(1);
        chk("t2_start_coins", coins_left, 3);
        chk("t2_start_timer", timer, 5);
        start    = 1'b0;
        coin_hit = 1'b1;
        cyc(1);
        chk("t2_coin1", coins_left, 2);
        coin_hit = 1'b0;
        cyc(1);
        coin_hit = 1'b1;
        cyc(1);
        chk("t2_coin2", coins_left, 1);
        coin_hit = 1'b0;
        cyc(1);
        chk("t2_tick_timer", timer, 4);
        chk("t2_tick_sec", sec_pulse, 1);
        coin_hit = 1'b1;
        cyc(1);
        chk("t2_coin3", coins_left, 0);
        chk("t2_win", win, 1);
        chk("t2_over", game_over, 1);
        chk("t2_timer", timer, 4);
        coin_hit = 1'b0;
        cyc(8);
        chk("t2_frozen_timer", timer, 4);
        chk("t2_frozen_win", win, 1);

        // 3. no coins -> timer runs out -> LOSS
        start = 1'b1;
        cyc(1);
        chk("t3_reload_coins", coins_left, 3);
        chk("t3_reload_timer", timer, 5);
        chk("t3_reload_win", win, 0);
        chk("t3_reload_over", game_over, 0);
        start = 1'b0;
        for (int s = 4; s >= 0; s--) begin
            cyc(3);
            chk("t3_pre_timer", timer, s + 1);
            chk("t3_pre_sec", sec_pulse, 0);
            cyc(1);
            chk("t3_tick_timer", timer, s);
            chk("t3_tick_sec", sec_pulse, 1);
        end
        chk("t3_loss_coins", coins_left, 0);
        chk("t3_loss_win", win, 0);
        chk("t3_loss_over", game_over, 1);
        cyc(4);
        chk("t3_frozen_timer", timer, 0);
        chk("t3_frozen_sec", sec_pulse, 0);

        // 4. coin_hit held high: one decrement only, and none across a restart
        start = 1'b1;
        cyc(1);
        start    = 1'b0;
        coin_hit = 1'b1;
        cyc(1);
        chk("t4_one_dec", coins_left, 2);
        cyc(15);
        chk("t4_held_coins", coins_left, 2);
        chk("t4_held_timer", timer, 1);
        cyc(4);
        chk("t4_loss_coins", coins_left, 0);
        chk("t4_loss_over", game_over, 1);
        cyc(22);
        chk("t4_loss_frozen", coins_left, 0);
        start = 1'b1;
        cyc(1);
        chk("t4_restart_coins", coins_left, 3);
        chk("t4_restart_timer", timer, 5);
        start = 1'b0;
        cyc(6);
        chk("t4_held_restart", coins_left, 3);
        chk("t4_restart_tick", timer, 4);
        coin_hit = 1'b0;

        // 5. coin+tick together, then last coin on the final tick
        cyc(1);
        coin_hit = 1'b1;
        cyc(1);
        chk("t5_both_coins", coins_left, 2);
        chk("t5_both_timer", timer, 3);
        chk("t5_both_sec", sec_pulse, 1);
        coin_hit = 1'b0;
        cyc(1);
        coin_hit = 1'b1;
        cyc(1);
        chk("t5_coin", coins_left, 1);
        coin_hit = 1'b0;
        cyc(9);
        chk("t5_pre_timer", timer, 1);
        chk("t5_pre_coins", coins_left, 1);
        coin_hit = 1'b1;
        cyc(1);
        chk("t5_win", win, 1);
        chk("t5_over", game_over, 1);
        chk("t5_timer", timer, 1);
        chk("t5_coins", coins_left, 0);
        chk("t5_sec", sec_pulse, 0);
        coin_hit = 1'b0;

        // 6. reset mid-game, ignored start in PLAY, restart from LOSS
        start = 1'b1;
        cyc(1);
        chk("t6_start_coins", coins_left, 3);
        start    = 1'b0;
        coin_hit = 1'b1;
        cyc(1);
        coin_hit = 1'b0;
        cyc(8);
        chk("t6_pre_coins", coins_left, 2);
        chk("t6_pre_timer", timer, 3);
        rst = 1'b0;
        #1;
        chk("t6_rst_coins", coins_left, 3);
        chk("t6_rst_timer", timer, 5);
        chk("t6_rst_over", game_over, 0);
        chk("t6_rst_win", win, 0);
        cyc(1);
        rst = 1'b1;
        cyc(5);
        chk("t6_idle_timer", timer, 5);
        chk("t6_idle_coins", coins_left, 3);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(5);
        chk("t6_play_timer", timer, 4);
        start = 1'b1;
        cyc(1);
        chk("t6_ignored_start", timer, 4);
        chk("t6_ignored_coins", coins_left, 3);
        start = 1'b0;
        cyc(14);
        chk("t6_loss_over", game_over, 1);
        chk("t6_loss_win", win, 0);
        chk("t6_loss_coins", coins_left, 0);
        chk("t6_loss_timer", timer, 0);
        start = 1'b1;
        cyc(1);
        chk("t6_reload_coins", coins_left, 3);
        chk("t6_reload_timer", timer, 5);
        chk("t6_reload_over", game_over, 0);
        chk("t6_reload_win", win, 0);
        start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
